// File: rtl/tcsm_smtc_pipe.sv
// Two-stage, multi-lane converter between two's-complement and sign-magnitude words.
// Direction travels with each beat; TC minimum saturates and is counted at output transfer.
module tcsm_smtc_pipe #(
    parameter int W     = 5,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_dir,
    input  logic [LANES*W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_sat,
    input  logic               sat_clr,
    output logic [CNT_W-1:0]   sat_cnt
);

    localparam int PC_W = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [W-1:0] ONE = W'(1);

    logic               s1_valid;
    logic               s1_dir;
    logic [LANES*W-1:0] s1_data;
    logic               s1_en;
    logic               s2_en;
    logic               out_fire;
    logic [LANES*W-1:0] conv_data;
    logic [LANES-1:0]   conv_sat;
    logic [PC_W-1:0]    sat_pop;
    logic [SUM_W-1:0]   cnt_sum;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    assign out_fire = out_valid && out_ready;

    // Returns {sat, word}; dir 0 = TC->SM, 1 = SM->TC.
    function automatic logic [W:0] conv_lane(input logic [W-1:0] x, input logic dir);
        logic [W-1:0] neg_x;
        logic [W-1:0] neg_mag;
        neg_x     = ~x + ONE;
        neg_mag   = ~{1'b0, x[W-2:0]} + ONE;
        conv_lane = {1'b0, x};
        if (x[W-1]) begin
            if (!dir) begin
                if (x[W-2:0] == '0) conv_lane = {1'b1, 1'b1, {(W-1){1'b1}}};
                else                conv_lane = {1'b0, 1'b1, neg_x[W-2:0]};
            end else begin
                if (x[W-2:0] == '0) conv_lane = '0;
                else                conv_lane = {1'b0, neg_mag};
            end
        end
    endfunction

    always_comb begin
        conv_data = '0;
        conv_sat  = '0;
        for (int i = 0; i < LANES; i++) begin
            {conv_sat[i], conv_data[i*W +: W]} = conv_lane(s1_data[i*W +: W], s1_dir);
        end
    end

    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_pop = sat_pop + PC_W'(out_sat[i]);
        end
        cnt_sum = {1'b0, sat_cnt} + SUM_W'(sat_pop);
    end

    // NOTE: all state uses non-blocking (<=) so each stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dir   <= 1'b0;
            s1_data  <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            s1_dir   <= in_dir;
            s1_data  <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= conv_data;
                out_sat  <= conv_sat;
            end
        end
    end

    // Clear wins over a same-cycle increment; the sum carry bit signals overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (out_fire) begin
            sat_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: doc/tcsm_smtc_pipe.md
Name: tcsm_smtc_pipe

Overview:
- Multi-lane, pipelined converter between two's-complement (TC) and sign-magnitude (SM) for LLR/message words in the LDPC decoder datapath.
- Sits between the variable-node update (TC arithmetic) and the min-sum check-node unit (SM compare/sign logic), in either direction.
- Conversion direction is selected per beat.
- Provides valid/ready flow control, saturation of the unrepresentable TC minimum, and a saturation event counter.

Parameters:
- W, 5, bits per lane word (sign included), W >= 3.
- LANES, 4, number of words converted in parallel per beat.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_dir  input  1  0 = TC->SM, 1 = SM->TC; sampled with the beat.
- in_data  input  LANES*W  packed lanes; lane i occupies bits [i*W +: W].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  LANES*W  converted lanes, same packing.
- out_sat  output  LANES  per-lane saturation flag for the current output beat.
- sat_clr  input  1  synchronous clear of the saturation counter.
- sat_cnt  output  CNT_W  saturation event count.

Behaviour:
- Reset is asynchronous, active-low. Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0, sat_cnt=0, and all stage valids cleared.
- Reset asserted mid-operation discards all in-flight beats; nothing is emitted after release until a new beat is accepted.
- Pipeline has two register stages.
  - S1 captures in_data and in_dir.
  - S2 holds the converted result and drives out_*.
  - Latency is 2 cycles from accept (in_valid & in_ready) to out_valid, when not stalled.
- Handshake and stall rules:
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en, a combinational function of registered state and out_ready only; it never depends on in_valid.
  - Beat transfer occurs on in_valid & in_ready; output transfer occurs on out_valid & out_ready.
  - Under stall, out_data, out_sat and out_valid hold stable; no beat is lost or duplicated.
  - Sustained throughput is 1 beat/cycle with out_ready held high.
- TC->SM, per lane, with x = W-bit TC value:
  - x >= 0: output = x unchanged.
  - x < 0 and x != -2^(W-1): output = {1, -x[W-2:0]}.
  - x == -2^(W-1) (1 followed by zeros): output = {1, all ones}, i.e. -(2^(W-1)-1), and out_sat[i]=1.
- SM->TC, per lane, with s = sign bit and m = magnitude:
  - s=0: output = {0, m}.
  - s=1, m != 0: output = two's complement of m, sign-extended to W bits.
  - s=1, m = 0 (negative zero): output = all zeros, out_sat[i]=0.
  - SM->TC never saturates.
- out_sat is registered alongside out_data in S2 and is valid only while out_valid=1.
- Saturation counter:
  - Adds popcount(out_sat) at every output transfer (out_valid & out_ready), not on S2 load.
  - Saturates at 2^CNT_W - 1 and never wraps.
  - sat_clr=1 sets it to 0 on the next edge; an increment in the same cycle is dropped (clear wins).
- in_dir is carried per beat; mixed-direction back-to-back beats are legal and converted independently.

Test Plan:
- W=5, LANES=4, dir=0, lanes {10001,00101,11111,00000} with out_ready=1 -> 2 cycles later out_data lanes {11111,00101,10001,00000}, out_sat=0000, sat_cnt stays 0.
- dir=0, lanes {10000,10000,01111,10000}, followed by one out_ready beat -> lanes {11111,11111,01111,11111}, out_sat=1011, sat_cnt=3.
- dir=1, lanes {10101,10000,01010,11111} -> lanes {11011,00000,01010,10001}, out_sat=0000.
- Stream 8 beats with out_ready toggling 1,0,0,1,... and alternating dir:
  - outputs must be in order, unduplicated, and stable while stalled;
  - in_ready must fall only when both stages are full;
  - back-to-back with out_ready=1 gives 1 beat/cycle.
- Preload sat_cnt to 0xFFFE via 2 saturating beats per lane config, run more saturating beats -> sat_cnt holds at 0xFFFF; assert sat_clr in the same cycle as a saturating transfer -> sat_cnt=0.
- Two beats in flight, pulse rst_n low asynchronously between clock edges -> out_valid=0 and sat_cnt=0 immediately; no output appears after release without new input.
